hwpe_ctrl_periph_arbiter: RTL

- Shares one peripheral-bus slave (req/gnt/add/wen/be/data/id, r_data/r_valid/r_id protocol) among N_MASTERS requesters using round-robin arbitration.
- Sits between the cluster-side masters and the HWPE register-file slave port.
- Extends the outgoing id with the master index, so responses are routed back by r_id.
- Limits outstanding transactions per master and holds the grant stable while the slave stalls.

---
 rtl/hwpe_ctrl_package.sv | 22 ++
 rtl/hwpe_ctrl_rr_picker.sv | 41 ++++
 rtl/hwpe_ctrl_periph_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/hwpe_ctrl_package.sv
// Shared types and helpers for the HWPE control-side peripheral logic.
//   sel_w()      : index width for n masters, never less than one bit.
//   periph_req_t : request fields of one peripheral-bus master, used for muxing.
//                  The id field is sized for the widest id any instance uses;
//                  consumers truncate it back to their own ID_WIDTH.
package hwpe_ctrl_package;

  localparam int unsigned PeriphIdMaxW = 32;

  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [31:0]             add;
    logic                    wen;
    logic [3:0]              be;
    logic [31:0]             data;
    logic [PeriphIdMaxW-1:0] id;
  } periph_req_t;

endpackage

// File: rtl/hwpe_ctrl_rr_picker.sv
// Combinational round-robin priority scan.
//   req   : candidate vector, one bit per master
//   start : index with highest priority this cycle
//   idx   : first set index found scanning start, start+1, ... modulo N
//   found : at least one bit of req is set
// Implemented as "lowest set bit at or above start, else lowest set bit overall",
// which is the same as a modular scan without needing a modulo operator.
module hwpe_ctrl_rr_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic             found_hi;
  logic [SEL_W-1:0] idx_hi;
  logic [SEL_W-1:0] idx_lo;

  always_comb begin
    found    = 1'b0;
    found_hi = 1'b0;
    idx_lo   = '0;
    idx_hi   = '0;
    // Descending loop so the lowest matching index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found  = 1'b1;
        idx_lo = SEL_W'(i);
        if (i >= int'(start)) begin
          found_hi = 1'b1;
          idx_hi   = SEL_W'(i);
        end
      end
    end
    idx = found_hi ? idx_hi : idx_lo;
  end

endmodule

// File: rtl/hwpe_ctrl_periph_arbiter.sv
// Round-robin arbiter sharing one peripheral-bus slave among N_MASTERS masters.
//   in_*  : master-side ports, fields packed per master (master i at slice i)
//   out_* : slave-side port; out_id_o carries {master index, master id} so the
//           response can be routed back by the top SEL_W bits of out_r_id_i
//   err_o : sticky protocol error (dropped locked request, unroutable response,
//           response to a master with nothing outstanding)
// A master that is offered but not granted is locked until the slave grants it.
// Each master may have at most MAX_OUTSTANDING granted-but-unanswered requests.
// clear_i is a synchronous active-high reset.
module hwpe_ctrl_periph_arbiter
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned  N_MASTERS       = 4,
  parameter int unsigned  ID_WIDTH        = 8,
  parameter int unsigned  MAX_OUTSTANDING = 2,
  localparam int unsigned SEL_W           = sel_w(N_MASTERS)
) (
  input  logic                            clk_i,
  input  logic                            clear_i,
  input  logic [N_MASTERS-1:0]            in_req_i,
  output logic [N_MASTERS-1:0]            in_gnt_o,
  input  logic [N_MASTERS*32-1:0]         in_add_i,
  input  logic [N_MASTERS-1:0]            in_wen_i,
  input  logic [N_MASTERS*4-1:0]          in_be_i,
  input  logic [N_MASTERS*32-1:0]         in_data_i,
  input  logic [N_MASTERS*ID_WIDTH-1:0]   in_id_i,
  output logic [N_MASTERS*32-1:0]         in_r_data_o,
  output logic [N_MASTERS-1:0]            in_r_valid_o,
  output logic [N_MASTERS*ID_WIDTH-1:0]   in_r_id_o,
  output logic                            out_req_o,
  input  logic                            out_gnt_i,
  output logic [31:0]                     out_add_o,
  output logic                            out_wen_o,
  output logic [3:0]                      out_be_o,
  output logic [31:0]                     out_data_o,
  output logic [ID_WIDTH+SEL_W-1:0]       out_id_o,
  input  logic [31:0]                     out_r_data_i,
  input  logic                            out_r_valid_i,
  input  logic [ID_WIDTH+SEL_W-1:0]       out_r_id_i,
  output logic                            err_o
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  logic [SEL_W-1:0] rr_q, rr_d;
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_idx_q, lock_idx_d;
  logic [CntW-1:0]  cnt_q [N_MASTERS];
  logic [CntW-1:0]  cnt_d [N_MASTERS];
  logic             err_q, err_d;

  periph_req_t      req_arr [N_MASTERS];
  periph_req_t      sel_req;
  logic [N_MASTERS-1:0] eligible;
  logic [N_MASTERS-1:0] win_oh;
  logic [N_MASTERS-1:0] r_hit;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic [SEL_W-1:0] winner;
  logic             lock_req;
  logic             lock_hit;
  logic             lock_drop;
  logic             hs;
  logic [SEL_W-1:0] r_idx;
  logic             r_in_range;
  logic             cnt_err;
  logic             unused_id_hi;

  // Per-master request fields and eligibility.
  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      req_arr[i].add  = in_add_i[i*32 +: 32];
      req_arr[i].wen  = in_wen_i[i];
      req_arr[i].be   = in_be_i[i*4 +: 4];
      req_arr[i].data = in_data_i[i*32 +: 32];
      req_arr[i].id   = PeriphIdMaxW'(in_id_i[i*ID_WIDTH +: ID_WIDTH]);
      eligible[i]     = in_req_i[i] && (cnt_q[i] < CntW'(MAX_OUTSTANDING));
    end
  end

  hwpe_ctrl_rr_picker #(
    .N     (N_MASTERS),
    .SEL_W (SEL_W)
  ) u_picker (
    .req   (eligible),
    .start (rr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // A locked master keeps the slot while it keeps requesting; its count cannot
  // have grown since it was picked because counts only grow on a grant.
  always_comb begin
    lock_req = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (lock_idx_q == SEL_W'(i)) lock_req = in_req_i[i];
    end
  end

  assign lock_hit  = lock_q && lock_req;
  assign lock_drop = lock_q && !lock_req;
  assign winner    = lock_hit ? lock_idx_q : pick_idx;
  assign out_req_o = lock_hit || pick_found;
  assign hs        = out_req_o && out_gnt_i;

  always_comb begin
    sel_req = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      win_oh[i] = out_req_o && (winner == SEL_W'(i));
      if (winner == SEL_W'(i)) sel_req = req_arr[i];
    end
  end

  assign in_gnt_o     = win_oh & {N_MASTERS{out_gnt_i}};
  assign out_add_o    = sel_req.add;
  assign out_wen_o    = sel_req.wen;
  assign out_be_o     = sel_req.be;
  assign out_data_o   = sel_req.data;
  assign out_id_o     = {winner, sel_req.id[ID_WIDTH-1:0]};
  assign unused_id_hi = ^sel_req.id;

  // Response routing: only the valid is demuxed, data and id are broadcast.
  assign r_idx = out_r_id_i[ID_WIDTH +: SEL_W];

  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      r_hit[i] = (r_idx == SEL_W'(i));
    end
  end

  assign r_in_range   = |r_hit;
  assign in_r_valid_o = r_hit & {N_MASTERS{out_r_valid_i}};
  assign in_r_data_o  = {N_MASTERS{out_r_data_i}};
  assign in_r_id_o    = {N_MASTERS{out_r_id_i[ID_WIDTH-1:0]}};

  // Outstanding counters: a grant and a response in the same cycle cancel out.
  always_comb begin
    cnt_err = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      cnt_d[i] = cnt_q[i];
      if ((hs && win_oh[i]) && !in_r_valid_o[i]) begin
        if (cnt_q[i] != CntW'(MAX_OUTSTANDING)) cnt_d[i] = cnt_q[i] + CntW'(1);
      end else if (in_r_valid_o[i] && !(hs && win_oh[i])) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CntW'(1);
        else                cnt_err  = 1'b1;
      end
    end
  end

  // Priority pointer and lock.
  always_comb begin
    rr_d       = rr_q;
    lock_d     = 1'b0;
    lock_idx_d = lock_idx_q;
    if (hs) begin
      rr_d = (winner == SEL_W'(N_MASTERS - 1)) ? '0 : winner + SEL_W'(1);
    end else if (out_req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = winner;
    end
  end

  assign err_d = err_q || lock_drop || cnt_err || (out_r_valid_i && !r_in_range);
  assign err_o = err_q;

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < N_MASTERS; i++) cnt_q[i] <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
      for (int i = 0; i < N_MASTERS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule
